// File: rtl/red_pkg.sv
// Shared constants and elaboration-time helpers for the red_pipe lane-sum reduction pipeline.
package red_pkg;

  localparam logic RED_MODE_LEGACY = 1'b0;
  localparam logic RED_MODE_SIGNED = 1'b1;

  function automatic int unsigned lanes(input int unsigned data_w, input int unsigned lane_w);
    return (2 * data_w) / lane_w;
  endfunction

  function automatic int unsigned levels(input int unsigned n);
    return unsigned'($clog2(n));
  endfunction

  function automatic int unsigned sum_w(input int unsigned lane_w, input int unsigned lvls);
    return lane_w + lvls;
  endfunction

  // Bit offset of tree level k in the flattened level bus (level 0 holds the raw lanes).
  function automatic int unsigned lvl_off(input int unsigned n, input int unsigned lane_w,
                                          input int unsigned k);
    int unsigned off;
    off = 0;
    for (int unsigned j = 0; j < k; j++) begin
      off += (n >> j) * (lane_w + j);
    end
    return off;
  endfunction

endpackage

// File: rtl/red_add_stage.sv
// One adder-tree level: pairwise mode-aware widening adds into a stallable register stage.
module red_add_stage
  import red_pkg::*;
#(
  parameter int unsigned IN_N = 8,
  parameter int unsigned IN_W = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  input  logic                             in_mode,
  input  logic [IN_N*IN_W-1:0]             in_data,
  output logic                             out_valid,
  output logic                             out_mode,
  input  logic                             out_ready,
  output logic [(IN_N/2)*(IN_W+1)-1:0]     out_data
);

  localparam int unsigned OUT_N = IN_N / 2;
  localparam int unsigned OUT_W = IN_W + 1;

  logic                   load_c;
  logic [OUT_N*OUT_W-1:0] sum_c;

  // Widening by one bit keeps every pairwise sum exact in either lane signedness.
  function automatic logic [OUT_W-1:0] ext(input logic [IN_W-1:0] v, input logic m);
    return (m == RED_MODE_SIGNED) ? {v[IN_W-1], v} : {1'b0, v};
  endfunction

  // Bubble-collapsing: load whenever empty or the held entry is leaving this cycle.
  assign load_c = !out_valid || out_ready;

  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < OUT_N; i++) begin
      sum_c[i*OUT_W +: OUT_W] = ext(in_data[(2*i)*IN_W +: IN_W], in_mode)
                              + ext(in_data[(2*i+1)*IN_W +: IN_W], in_mode);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_mode  <= RED_MODE_LEGACY;
      out_data  <= '0;
    end else if (load_c) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_mode <= in_mode;
        out_data <= sum_c;
      end
    end
  end

endmodule

// File: rtl/red_pipe.sv
// Pipelined lane-sum reduction (RED) unit with valid/ready on both sides.
// Optional RED_STATS_EN adds the 16-bit wrapping red_count completed-result counter.
module red_pipe
  import red_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANE_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              red_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] des_data
`ifdef RED_STATS_EN
  ,
  output logic [15:0]       red_count
`endif
);

  localparam int unsigned LANES     = lanes(DATA_W, LANE_W);
  localparam int unsigned SRC_LANES = DATA_W / LANE_W;
  localparam int unsigned LEVELS    = levels(LANES);
  localparam int unsigned SUM_W     = sum_w(LANE_W, LEVELS);
  localparam int unsigned BUS_W     = lvl_off(LANES, LANE_W, LEVELS + 1);
  localparam int unsigned RES_OFF   = lvl_off(LANES, LANE_W, LEVELS);

  logic [BUS_W-1:0] lvl_bus;
  logic [LEVELS:0]  valid_s;
  logic [LEVELS:0]  mode_s;
  logic [LEVELS:0]  ready_c;
  logic             mode_unused;
  logic [SUM_W-1:0] sum;

  // Interleave lanes so each level-1 adder pairs lane i of src1 with lane i of src2.
  for (genvar i = 0; i < SRC_LANES; i++) begin : g_lane
    assign lvl_bus[(2*i)*LANE_W +: LANE_W]   = src1[i*LANE_W +: LANE_W];
    assign lvl_bus[(2*i+1)*LANE_W +: LANE_W] = src2[i*LANE_W +: LANE_W];
  end

  assign valid_s[0]      = in_valid;
  assign mode_s[0]       = red_mode;
  assign ready_c[LEVELS] = out_ready;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int unsigned IN_N  = LANES >> k;
    localparam int unsigned IN_W  = LANE_W + k;
    localparam int unsigned I_OFF = lvl_off(LANES, LANE_W, k);
    localparam int unsigned O_OFF = lvl_off(LANES, LANE_W, k + 1);

    // Stage k takes new data unless it and every stage after it are full and the output stalls.
    assign ready_c[k] = out_ready || !(&valid_s[LEVELS:k+1]);

    red_add_stage #(
      .IN_N (IN_N),
      .IN_W (IN_W)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (valid_s[k]),
      .in_mode   (mode_s[k]),
      .in_data   (lvl_bus[I_OFF +: IN_N*IN_W]),
      .out_valid (valid_s[k+1]),
      .out_mode  (mode_s[k+1]),
      .out_ready (ready_c[k+1]),
      .out_data  (lvl_bus[O_OFF +: (IN_N/2)*(IN_W+1)])
    );
  end

  assign in_ready    = ready_c[0];
  assign out_valid   = valid_s[LEVELS];
  assign mode_unused = mode_s[LEVELS];

  // Both modes read the final sum as two's complement, which reproduces legacy RED.
  assign sum      = lvl_bus[RES_OFF +: SUM_W];
  assign des_data = DATA_W'($signed(sum));

`ifdef RED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_count <= 16'd0;
    end else if (out_valid && out_ready) begin
      red_count <= red_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_red_pipe.sv
// Randomized self-checking bench for red_pipe against a lane-arithmetic reference model.
module tb_red_pipe;
  import red_pkg::*;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned LANE_W  = 4;
  localparam int          N_LANES = DATA_W / LANE_W;
  localparam int          SUM_W   = LANE_W + $clog2(2 * N_LANES);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic              red_mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] des_data;
`ifdef RED_STATS_EN
  logic [15:0]       red_count;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_in     = 0;
  int          n_out    = 0;
  logic [15:0] exp_q [$];
  logic        held_pending = 1'b0;
  logic [15:0] held_data = 16'd0;
  logic        last_acc = 1'b0;

  red_pipe #(.DATA_W(DATA_W), .LANE_W(LANE_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src1      (src1),
    .src2      (src2),
    .red_mode  (red_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .des_data  (des_data)
`ifdef RED_STATS_EN
    ,
    .red_count (red_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sum of all lanes as plain integers, then the legacy SUM_W-bit two's-complement view.
  function automatic logic [15:0] ref_sum(input logic [15:0] a, input logic [15:0] b,
                                          input logic m);
    int s;
    int v;
    s = 0;
    for (int i = 0; i < N_LANES; i++) begin
      v = int'(a[i*LANE_W +: LANE_W]);
      if (m == RED_MODE_SIGNED && v >= 8) v -= 16;
      s += v;
      v = int'(b[i*LANE_W +: LANE_W]);
      if (m == RED_MODE_SIGNED && v >= 8) v -= 16;
      s += v;
    end
    s = s & ((1 << SUM_W) - 1);
    if (s >= (1 << (SUM_W - 1))) s -= (1 << SUM_W);
    return 16'(s);
  endfunction

  // One cycle from a falling edge: drive, sample handshakes, score, advance to next falling edge.
  task automatic step(input logic iv, input logic [15:0] s1, input logic [15:0] s2,
                      input logic m, input logic ordy);
    in_valid  = iv;
    src1      = s1;
    src2      = s2;
    red_mode  = m;
    out_ready = ordy;
    #1;
    if (held_pending) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(des_data), 32'(held_data));
      held_pending = 1'b0;
    end
    last_acc = iv && in_ready;
    if (out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        chk("out_data", 32'(des_data), 32'(exp_q.pop_front()));
        n_out++;
      end
    end
    if (out_valid && !ordy) begin
      held_pending = 1'b1;
      held_data    = des_data;
    end
    if (last_acc) begin
      exp_q.push_back(ref_sum(s1, s2, m));
      n_in++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single transaction into an empty pipe: checks latency and the exact result.
  task automatic run_one(input logic [15:0] s1, input logic [15:0] s2, input logic m,
                         input logic [15:0] exp, input string tag);
    step(1'b1, s1, s2, m, 1'b1);
    chk({tag, "_acc"}, 32'(last_acc), 32'd1);
    chk({tag, "_lat0"}, 32'(out_valid), 32'd0);
    step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(des_data), 32'(exp));
    step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
  endtask

  initial begin
    int cyc;
    int acc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    src1      = 16'd0;
    src2      = 16'd0;
    red_mode  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_des_data", 32'(des_data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed values with latency checks.
    run_one(16'hFFFF, 16'hFFFF, RED_MODE_LEGACY, 16'hFFF8, "legacy_ones");
    run_one(16'h1234, 16'h5678, RED_MODE_LEGACY, 16'h0024, "legacy_seq");
    run_one(16'h8888, 16'h8888, RED_MODE_SIGNED, 16'hFFC0, "signed_min");
    run_one(16'h7777, 16'h7777, RED_MODE_SIGNED, 16'h0038, "signed_max");
    run_one(16'h0000, 16'h0000, RED_MODE_SIGNED, 16'h0000, "signed_zero");

    // Backpressure: three fill the pipe, the fourth waits for the release cycle.
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'(16'h1111 * (i + 1)), 16'h0F0F, RED_MODE_LEGACY, 1'b0);
      if (last_acc) acc++;
    end
    chk("bp_accepted", 32'(acc), 32'd3);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    step(1'b1, 16'hABCD, 16'h9876, RED_MODE_SIGNED, 1'b0);
    chk("bp_stall_no_acc", 32'(last_acc), 32'd0);
    step(1'b1, 16'hABCD, 16'h9876, RED_MODE_SIGNED, 1'b1);
    chk("bp_release_acc", 32'(last_acc), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_stream_valid", 32'(out_valid), 32'd1);
      step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
    end
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Full-rate streaming with the consumer always ready.
    n_in  = 0;
    n_out = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
      chk("tp_acc", 32'(last_acc), 32'd1);
    end
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
      cyc++;
    end
    chk("tp_count_out", 32'(n_out), 32'd8);

    // Random valid and random backpressure.
    n_in  = 0;
    n_out = 0;
    acc   = 0;
    cyc   = 0;
    while (acc < 20 && cyc < 400) begin
      step(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), 1'($urandom),
           1'($urandom_range(0, 2) != 0));
      if (last_acc) acc++;
      cyc++;
    end
    chk("rand_accepted", 32'(acc), 32'd20);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
      cyc++;
    end
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_in_eq_out", 32'(n_out), 32'(n_in));

    // Reset with results in flight: everything in flight is dropped.
    step(1'b1, 16'h1111, 16'h2222, RED_MODE_LEGACY, 1'b0);
    step(1'b1, 16'h3333, 16'h4444, RED_MODE_LEGACY, 1'b0);
    step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_des_data", 32'(des_data), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    held_pending = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("no_stale", 32'(out_valid), 32'd0);
      step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
    end
    run_one(16'h0F0F, 16'hF0F0, RED_MODE_LEGACY, 16'h003C, "post_rst");

`ifdef RED_STATS_EN
    chk("stats_after_one", 32'(red_count), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
    end
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
      cyc++;
    end
    chk("stats_five", 32'(red_count), 32'd5);
    force dut.red_count = 16'hFFFF;
    @(negedge clk);
    release dut.red_count;
    #1;
    chk("stats_preload", 32'(red_count), 32'hFFFF);
    @(negedge clk);
    run_one(16'h0001, 16'h0001, RED_MODE_LEGACY, 16'h0002, "stats_wrap_txn");
    chk("stats_wrap", 32'(red_count), 32'h0000);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
